fir_out_decim: RTL and testbench



---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_out_decim_if.sv | 9 +
 rtl/fir_sync_fifo.sv | 48 ++++
 rtl/fir_out_decim.sv | 70 +++++++
 tb/tb_fir_out_decim.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared widths and the output saturation helper for the FIR block family.
package fir_pkg;
  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                        clip;
    logic signed [SAT_MAX_W-1:0] q;
  } sat_t;

  // Caller sign-extends its (IN_W+1)-bit value into the wide container.
  // q is clamped to the out_w-bit signed range; its low out_w bits are the result.
  function automatic sat_t sat_round(input logic signed [SAT_MAX_W-1:0] v, input int out_w);
    logic signed [SAT_MAX_W-1:0] hi, lo;
    sat_t r;
    hi     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (out_w - 1));
    r.clip = 1'b0;
    r.q    = v;
    if (v > hi) begin
      r.q    = hi;
      r.clip = 1'b1;
    end else if (v < lo) begin
      r.q    = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/fir_out_decim_if.sv
// Valid/ready output stream of the decimator; master drives data/valid.
interface fir_out_decim_if #(parameter int OUT_W = fir_pkg::FIR_OUT_W);
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; writes when full are refused unless a read frees a slot.
module fir_sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head reads as zero when empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= nxt(wptr);
      if (do_rd) rptr <= nxt(rptr);
      if (do_wr != do_rd) level <= do_wr ? level + 1'b1 : level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: decimate, round-half-up, shift, saturate, buffer onto a valid/ready stream.
module fir_out_decim import fir_pkg::*; #(
  parameter  int IN_W  = FIR_IN_W,
  parameter  int OUT_W = FIR_OUT_W,
  parameter  int SHIFT = 8,
  parameter  int DECIM = 4,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] y_in,
  input  logic                   y_valid,
  input  logic                   clr_flags,
  fir_out_decim_if.master        ob,
  output logic [LW-1:0]          fifo_level,
  output logic                   sat_flag,
  output logic                   ovf_flag
);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [PW-1:0]          phase;
  logic                   keep;
  logic                   s1_vld;
  logic signed [IN_W:0]   rnd, s1_q;
  sat_t                   sat;
  logic [OUT_W-1:0]       fifo_rd;
  logic                   full, empty, pop;

  assign keep = y_valid && (phase == '0);
  // One extra bit so adding the rounding half never wraps.
  assign rnd  = {y_in[IN_W-1], y_in} + HALF;
  assign sat  = sat_round(SAT_MAX_W'(s1_q), OUT_W);
  assign pop  = !empty && ob.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      s1_vld   <= 1'b0;
      s1_q     <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (y_valid) phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
      s1_vld <= keep;
      if (keep) s1_q <= rnd >>> SHIFT;
      // A set event in the same cycle as clr_flags takes priority.
      if (s1_vld && sat.clip)      sat_flag <= 1'b1;
      else if (clr_flags)          sat_flag <= 1'b0;
      if (s1_vld && full && !pop)  ovf_flag <= 1'b1;
      else if (clr_flags)          ovf_flag <= 1'b0;
    end
  end

  fir_sync_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_vld),
    .wr_data (sat.q[OUT_W-1:0]),
    .rd_en   (ob.out_ready),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign ob.out_data  = fifo_rd;
  assign ob.out_valid = !empty;
endmodule

// File: tb/tb_fir_out_decim.sv
// Scoreboard bench: two decimator instances (DECIM=1 and DECIM=4) share one stimulus stream.
module tb_fir_out_decim;
  import fir_pkg::*;
  localparam int DEPTH = 4;
  localparam int SHIFT = 8;

  logic               clk = 1'b0, rst = 1'b1;
  logic signed [31:0] y_in = '0;
  logic               y_valid = 1'b0, clr_flags = 1'b0, rdy = 1'b0;
  logic [2:0]         lvl1, lvl4;
  logic               sat1, sat4, ovf1, ovf4;

  fir_out_decim_if #(.OUT_W(16)) ob1 ();
  fir_out_decim_if #(.OUT_W(16)) ob4 ();
  assign ob1.out_ready = rdy;
  assign ob4.out_ready = rdy;

  fir_out_decim #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .clr_flags(clr_flags),
    .ob(ob1), .fifo_level(lvl1), .sat_flag(sat1), .ovf_flag(ovf1));
  fir_out_decim #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(4), .DEPTH(DEPTH)) u4 (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .clr_flags(clr_flags),
    .ob(ob4), .fifo_level(lvl4), .sat_flag(sat4), .ovf_flag(ovf4));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int dec [2] = '{1, 4};
  int phase [2], cnt [2], s1val [2];
  bit s1v [2], s1clip [2], msat [2], movf [2];
  int q0 [$], q1 [$], got0 [$], got1 [$];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: round half toward +inf, floor-divide by 2^SHIFT, clamp to 16-bit signed.
  function automatic void ref_out(input longint y, output int q, output bit clip);
    longint r, den, f;
    den  = longint'(1) <<< SHIFT;
    r    = y + den / 2;
    f    = (r >= 0) ? r / den : -((-r + den - 1) / den);
    clip = 1'b0;
    q    = int'(f);
    if (f > 32767)       begin q = 32767;  clip = 1'b1; end
    else if (f < -32768) begin q = -32768; clip = 1'b1; end
  endfunction

  // Behavioural model: queue occupancy, drop on full, sticky flags.
  task automatic model_step();
    bit pop, ssat, sovf;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        phase[d] = 0; s1v[d] = 0; cnt[d] = 0; msat[d] = 0; movf[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        pop = (cnt[d] > 0) && rdy; ssat = 0; sovf = 0;
        if (s1v[d]) begin
          ssat = s1clip[d];
          if (cnt[d] < DEPTH || pop) begin
            if (d == 0) q0.push_back(s1val[d]); else q1.push_back(s1val[d]);
            cnt[d]++;
          end else sovf = 1;
        end
        if (pop) cnt[d]--;
        msat[d] = ssat || (msat[d] && !clr_flags);
        movf[d] = sovf || (movf[d] && !clr_flags);
        s1v[d]  = y_valid && (phase[d] == 0);
        if (s1v[d]) ref_out(longint'(y_in), s1val[d], s1clip[d]);
        if (y_valid) phase[d] = (phase[d] + 1) % dec[d];
      end
    end
  endtask

  task automatic mon_one(input int d, input logic v, input logic signed [15:0] data,
                         input logic [2:0] lvl, input logic s, input logic o);
    int e;
    chk($sformatf("valid[%0d]", d), {63'd0, v}, {63'd0, cnt[d] > 0});
    chk($sformatf("level[%0d]", d), {61'd0, lvl}, cnt[d]);
    chk($sformatf("sat[%0d]", d), {63'd0, s}, {63'd0, msat[d]});
    chk($sformatf("ovf[%0d]", d), {63'd0, o}, {63'd0, movf[d]});
    if (v === 1'b1 && rdy) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output[%0d]: got %0d expected none", d, data);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("data[%0d]", d), data, e);
        if (d == 0) got0.push_back(int'(data)); else got1.push_back(int'(data));
      end
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin
    @(negedge clk);
    mon_one(0, ob1.out_valid, ob1.out_data, lvl1, sat1, ovf1);
    mon_one(1, ob4.out_valid, ob4.out_data, lvl4, sat4, ovf4);
  end

  task automatic cyc(input logic signed [31:0] y, input logic v);
    @(posedge clk); #1; y_in = y; y_valid = v;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc('0, 1'b0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; y_valid = 1'b0; clr_flags = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data", ob1.out_data, 0);
    chk("rst_valid", {63'd0, ob4.out_valid}, 0);
    chk("rst_level", {61'd0, lvl4}, 0);
    @(posedge clk); #1; rst = 1'b0; rdy = 1'b1;

    // Rounding and two-cycle latency
    got0.delete();
    cyc(32'sd4736, 1'b1); idle(2);
    @(negedge clk);
    chk("lat_valid", {63'd0, ob1.out_valid}, 1);
    chk("lat_data", ob1.out_data, 19);
    cyc(-32'sd4736, 1'b1); cyc(-32'sd128, 1'b1); idle(4);
    chk("rnd_count", got0.size(), 3);
    if (got0.size() == 3) begin
      chk("rnd_pos", got0[0], 19); chk("rnd_neg", got0[1], -18); chk("rnd_half", got0[2], 0);
    end

    // Saturation and flag clear
    cyc(32'sh7FFFFFFF, 1'b1); idle(2);
    @(negedge clk);
    chk("sat_hi", ob1.out_data, 32767);
    chk("sat_flag", {63'd0, sat1}, 1);
    cyc(32'sh80000000, 1'b1); idle(2);
    @(negedge clk);
    chk("sat_lo", ob1.out_data, -32768);
    @(posedge clk); #1; clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    chk("sat_clr", {63'd0, sat1}, 0);

    // Decimation by 4 with gaps
    do_reset(); got1.delete();
    for (int k = 1; k <= 8; k++) begin
      cyc(32'(256 * k), 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);
    chk("dec_count", got1.size(), 2);
    if (got1.size() == 2) begin chk("dec_first", got1[0], 1); chk("dec_second", got1[1], 5); end

    // Backpressure: fill, overflow, drain in order
    do_reset(); rdy = 1'b0;
    for (int k = 10; k <= 14; k++) cyc(32'(256 * k), 1'b1);
    idle(3);
    @(negedge clk);
    chk("bp_level", {61'd0, lvl1}, 4);
    chk("bp_ovf", {63'd0, ovf1}, 1);
    got0.delete();
    @(posedge clk); #1; rdy = 1'b1;
    idle(6);
    chk("bp_count", got0.size(), 4);
    if (got0.size() == 4) for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), got0[i], 10 + i);

    // Push and pop together while full
    do_reset(); rdy = 1'b0; got0.delete();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; y_in = 32'(256 * (20 + i)); y_valid = 1'b1; rdy = (i >= 5);
      if (i >= 5) begin
        @(negedge clk);
        chk("full_level", {61'd0, lvl1}, 4);
        chk("full_ovf", {63'd0, ovf1}, 0);
      end
    end
    idle(8);
    chk("full_count", got0.size(), 12);
    if (got0.size() == 12) for (int i = 0; i < 12; i++) chk($sformatf("full_order%0d", i), got0[i], 20 + i);

    // Reset mid-stream: three buffered in the DECIM=4 instance, phase 2
    do_reset(); rdy = 1'b0;
    for (int k = 0; k < 10; k++) cyc(32'(256 * (k + 1)), 1'b1);
    idle(1);
    @(negedge clk);
    chk("mid_level", {61'd0, lvl4}, 3);
    @(posedge clk); #1; rst = 1'b1; y_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, ob4.out_valid}, 0);
    chk("mid_rst_data", ob4.out_data, 0);
    chk("mid_rst_level1", {61'd0, lvl1}, 0);
    chk("mid_rst_ovf1", {63'd0, ovf1}, 0);
    rdy = 1'b1;
    cyc(32'sd4736, 1'b1); idle(2);
    @(negedge clk);
    chk("mid_first_valid", {63'd0, ob4.out_valid}, 1);
    chk("mid_first_data", ob4.out_data, 19);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      y_valid   = ($urandom_range(0, 2) != 0);
      y_in      = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                : 32'($urandom_range(0, 16777215)) - 32'sd8388608;
      rdy       = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr_flags = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1; rst = 1'b0; clr_flags = 1'b0; rdy = 1'b1;
    idle(10);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
